// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite types: response codes, register-file FSM states
// and the byte-lane merge helper used on register writes.
package axi4_lite_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_t;

    typedef enum logic {
        WR_COLLECT,
        WR_RESP
    } wr_state_t;

    typedef enum logic {
        RD_IDLE,
        RD_RESP
    } rd_state_t;

    localparam int MAX_DATA_W = 64;
    localparam int MAX_STRB_W = MAX_DATA_W / 8;

    // Narrower buses zero-extend into the 64-bit operands.
    function automatic logic [MAX_DATA_W-1:0] merge_strb(
        input logic [MAX_DATA_W-1:0] old_w,
        input logic [MAX_DATA_W-1:0] new_w,
        input logic [MAX_STRB_W-1:0] strb
    );
        logic [MAX_DATA_W-1:0] m;
        for (int i = 0; i < MAX_STRB_W; i++) begin
            m[8*i +: 8] = strb[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
        end
        return m;
    endfunction

endpackage

// File: rtl/axi4_lite_if.sv
// AXI4-Lite bus bundle with master and slave modports.
interface axi4_lite_if #(
    parameter int AXI4_LITE_ADDR_BIT_WIDTH = 32,
    parameter int AXI4_LITE_DATA_BIT_WIDTH = 32
);
    localparam int AW = AXI4_LITE_ADDR_BIT_WIDTH;
    localparam int DW = AXI4_LITE_DATA_BIT_WIDTH;

    logic          awvalid;
    logic          awready;
    logic [AW-1:0] awaddr;
    logic [2:0]    awprot;
    logic          wvalid;
    logic          wready;
    logic [DW-1:0] wdata;
    logic [DW/8-1:0] wstrb;
    logic          bvalid;
    logic          bready;
    logic [1:0]    bresp;
    logic          arvalid;
    logic          arready;
    logic [AW-1:0] araddr;
    logic [2:0]    arprot;
    logic          rvalid;
    logic          rready;
    logic [DW-1:0] rdata;
    logic [1:0]    rresp;

    modport slv_port (
        input  awvalid, awaddr, awprot,
        output awready,
        input  wvalid, wdata, wstrb,
        output wready,
        output bvalid, bresp,
        input  bready,
        input  arvalid, araddr, arprot,
        output arready,
        output rvalid, rdata, rresp,
        input  rready
    );

    modport mst_port (
        output awvalid, awaddr, awprot,
        input  awready,
        output wvalid, wdata, wstrb,
        input  wready,
        input  bvalid, bresp,
        output bready,
        output arvalid, araddr, arprot,
        input  arready,
        input  rvalid, rdata, rresp,
        output rready
    );

endinterface

// File: rtl/axi4_lite_reg_file_slv.sv
// AXI4-Lite register-file slave with independent write and read FSMs.
// Define AXI4_LITE_REG_FILE_SLV_ADDR_ERR_EN to answer out-of-range with SLVERR.
module axi4_lite_reg_file_slv
    import axi4_lite_pkg::*;
#(
    parameter int AXI4_LITE_ADDR_BIT_WIDTH = 32,
    parameter int AXI4_LITE_DATA_BIT_WIDTH = 32,
    parameter int NUM_REGS                 = 16
) (
    input  logic clk,
    input  logic sync_rst,
    axi4_lite_if.slv_port if_s_axi,
    output logic [NUM_REGS-1:0][AXI4_LITE_DATA_BIT_WIDTH-1:0] o_regs,
    output logic [NUM_REGS-1:0] o_wr_pulse
);

    localparam int AW     = AXI4_LITE_ADDR_BIT_WIDTH;
    localparam int DW     = AXI4_LITE_DATA_BIT_WIDTH;
    localparam int STRB_W = DW / 8;
    localparam int OFFS   = $clog2(STRB_W);
    localparam int IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

`ifdef AXI4_LITE_REG_FILE_SLV_ADDR_ERR_EN
    localparam resp_t OOR_RESP = SLVERR;
`else
    localparam resp_t OOR_RESP = OKAY;
`endif

    wr_state_t   wr_state;
    logic        aw_got;
    logic        w_got;
    logic [AW-1:0]     aw_addr_q;
    logic [DW-1:0]     w_data_q;
    logic [STRB_W-1:0] w_strb_q;
    resp_t       bresp_q;
    logic [NUM_REGS-1:0][DW-1:0] regs_q;
    logic [NUM_REGS-1:0] pulse_q;

    rd_state_t   rd_state;
    logic [DW-1:0] rdata_q;
    resp_t       rresp_q;

    logic awready_i, wready_i, arready_i;
    logic aw_hs, w_hs, ar_hs, commit;
    logic [AW-1:0]     wr_addr, wr_word, rd_word;
    logic [DW-1:0]     wr_data;
    logic [STRB_W-1:0] wr_strb;
    logic              wr_in_rng, rd_in_rng;
    logic [IDX_W-1:0]  wr_idx, rd_idx;
    logic [MAX_DATA_W-1:0] merged_full;

    always_comb begin
        awready_i = ~sync_rst & (wr_state == WR_COLLECT) & ~aw_got;
        wready_i  = ~sync_rst & (wr_state == WR_COLLECT) & ~w_got;
        arready_i = ~sync_rst & (rd_state == RD_IDLE);
        aw_hs     = if_s_axi.awvalid & awready_i;
        w_hs      = if_s_axi.wvalid & wready_i;
        ar_hs     = if_s_axi.arvalid & arready_i;
        // Bypass lets a handshake commit on the same edge it arrives.
        wr_addr   = aw_got ? aw_addr_q : if_s_axi.awaddr;
        wr_data   = w_got ? w_data_q : if_s_axi.wdata;
        wr_strb   = w_got ? w_strb_q : if_s_axi.wstrb;
        commit    = ~sync_rst & (wr_state == WR_COLLECT)
                  & (aw_got | aw_hs) & (w_got | w_hs);
        wr_word   = wr_addr >> OFFS;
        wr_in_rng = wr_word < AW'(NUM_REGS);
        wr_idx    = wr_word[IDX_W-1:0];
        rd_word   = if_s_axi.araddr >> OFFS;
        rd_in_rng = rd_word < AW'(NUM_REGS);
        rd_idx    = rd_word[IDX_W-1:0];
        merged_full = merge_strb(MAX_DATA_W'(regs_q[wr_idx]),
                                 MAX_DATA_W'(wr_data),
                                 MAX_STRB_W'(wr_strb));
    end

    always_ff @(posedge clk) begin
        if (sync_rst) begin
            wr_state  <= WR_COLLECT;
            aw_got    <= 1'b0;
            w_got     <= 1'b0;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bresp_q   <= OKAY;
            regs_q    <= '0;
            pulse_q   <= '0;
        end else begin
            pulse_q <= '0;
            unique case (wr_state)
                WR_COLLECT: begin
                    if (aw_hs) begin
                        aw_got    <= 1'b1;
                        aw_addr_q <= if_s_axi.awaddr;
                    end
                    if (w_hs) begin
                        w_got    <= 1'b1;
                        w_data_q <= if_s_axi.wdata;
                        w_strb_q <= if_s_axi.wstrb;
                    end
                    if (commit) begin
                        wr_state <= WR_RESP;
                        if (wr_in_rng) begin
                            regs_q[wr_idx]  <= merged_full[DW-1:0];
                            pulse_q[wr_idx] <= 1'b1;
                            bresp_q         <= OKAY;
                        end else begin
                            bresp_q <= OOR_RESP;
                        end
                    end
                end
                WR_RESP: begin
                    if (if_s_axi.bready) begin
                        aw_got   <= 1'b0;
                        w_got    <= 1'b0;
                        wr_state <= WR_COLLECT;
                    end
                end
                default: wr_state <= WR_COLLECT;
            endcase
        end
    end

    // Reads sample regs_q before any same-edge write lands: old value wins.
    always_ff @(posedge clk) begin
        if (sync_rst) begin
            rd_state <= RD_IDLE;
            rdata_q  <= '0;
            rresp_q  <= OKAY;
        end else begin
            unique case (rd_state)
                RD_IDLE: begin
                    if (ar_hs) begin
                        rd_state <= RD_RESP;
                        if (rd_in_rng) begin
                            rdata_q <= regs_q[rd_idx];
                            rresp_q <= OKAY;
                        end else begin
                            rdata_q <= '0;
                            rresp_q <= OOR_RESP;
                        end
                    end
                end
                RD_RESP: begin
                    if (if_s_axi.rready) begin
                        rd_state <= RD_IDLE;
                    end
                end
                default: rd_state <= RD_IDLE;
            endcase
        end
    end

    assign if_s_axi.awready = awready_i;
    assign if_s_axi.wready  = wready_i;
    assign if_s_axi.arready = arready_i;
    assign if_s_axi.bvalid  = ~sync_rst & (wr_state == WR_RESP);
    assign if_s_axi.rvalid  = ~sync_rst & (rd_state == RD_RESP);
    assign if_s_axi.bresp   = sync_rst ? OKAY : bresp_q;
    assign if_s_axi.rresp   = sync_rst ? OKAY : rresp_q;
    assign if_s_axi.rdata   = sync_rst ? '0 : rdata_q;
    assign o_regs           = sync_rst ? '0 : regs_q;
    assign o_wr_pulse       = sync_rst ? '0 : pulse_q;

    logic unused;
    assign unused = ^{if_s_axi.awprot, if_s_axi.arprot, merged_full};

endmodule
